// File: rtl/bitstream_pkg.sv
// Shared types for the stochastic-bitstream layer decoder.
// Holds the FSM state encoding and the window-length helper.
package bitstream_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } state_t;

    function automatic int window_len(input int log2);
        return 1 << log2;
    endfunction

endpackage

// File: rtl/bitstream_counter.sv
// Per-channel ones counter for one decode window.
// Wide enough to reach N without wrapping.
module bitstream_counter
    import bitstream_pkg::*;
#(
    parameter int WINDOW_LOG2 = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 enable,
    input  logic                 bit_in,
    output logic [WINDOW_LOG2:0] count
);

    logic [WINDOW_LOG2:0] count_d;
    logic [WINDOW_LOG2:0] count_q;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && bit_in) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/layer_decode.sv
// Decodes CHANNEL_COUNT stochastic bitstreams over a 2**WINDOW_LOG2 window.
// Define LAYER_DECODE_BIPOLAR_EN for bipolar results (2*count - N).
module layer_decode
    import bitstream_pkg::*;
#(
    parameter int CHANNEL_COUNT = 2,
    parameter int WINDOW_LOG2   = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [CHANNEL_COUNT-1:0] layer_output,
    input  logic                     start,
    input  logic                     result_ready,
    output int                       result_value [CHANNEL_COUNT-1:0],
    output logic                     result_valid,
    output logic                     busy
);

    localparam int CW = WINDOW_LOG2 + 1;
    localparam int N  = window_len(WINDOW_LOG2);
    localparam logic [WINDOW_LOG2-1:0] SAMPLE_LAST = '1;

    state_t                 state_d;
    state_t                 state_q;
    logic [WINDOW_LOG2-1:0] sample_d;
    logic [WINDOW_LOG2-1:0] sample_q;
    int                     result_d [CHANNEL_COUNT-1:0];
    int                     result_q [CHANNEL_COUNT-1:0];

    logic                   clear;
    logic                   counting;
    logic [CW-1:0]          count [CHANNEL_COUNT-1:0];
    logic [CW-1:0]          total [CHANNEL_COUNT-1:0];

    assign counting = (state_q == COUNT);

    for (genvar ch = 0; ch < CHANNEL_COUNT; ch++) begin : g_chan
        bitstream_counter #(
            .WINDOW_LOG2(WINDOW_LOG2)
        ) u_counter (
            .clk    (clk),
            .rst    (rst),
            .clear  (clear),
            .enable (counting),
            .bit_in (layer_output[ch]),
            .count  (count[ch])
        );
    end

    // The last sample is still in flight when DONE is entered, so fold it in here.
    always_comb begin
        for (int ch = 0; ch < CHANNEL_COUNT; ch++) begin
            total[ch] = count[ch] + CW'(layer_output[ch]);
        end
    end

    always_comb begin
        state_d  = state_q;
        sample_d = sample_q;
        result_d = result_q;
        clear    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = COUNT;
                    sample_d = '0;
                    clear    = 1'b1;
                end
            end
            COUNT: begin
                sample_d = sample_q + 1'b1;
                if (sample_q == SAMPLE_LAST) begin
                    state_d = DONE;
                    for (int ch = 0; ch < CHANNEL_COUNT; ch++) begin
`ifdef LAYER_DECODE_BIPOLAR_EN
                        result_d[ch] = (int'(32'(total[ch])) <<< 1) - N;
`else
                        result_d[ch] = int'(32'(total[ch]));
`endif
                    end
                end
            end
            DONE: begin
                if (result_ready) begin
                    if (start) begin
                        state_d  = COUNT;
                        sample_d = '0;
                        clear    = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            sample_q <= '0;
            for (int ch = 0; ch < CHANNEL_COUNT; ch++) begin
                result_q[ch] <= 0;
            end
        end else begin
            state_q  <= state_d;
            sample_q <= sample_d;
            result_q <= result_d;
        end
    end

    assign result_value = result_q;
    assign result_valid = (state_q == DONE);
    assign busy         = counting;

endmodule

// File: tb/tb_layer_decode.sv
// Self-checking bench for layer_decode with N=16, two channels.
// Expected values come from popcounts of the applied bitstreams.
module tb_layer_decode;

    localparam int WL = 4;
    localparam int NW = 16;
    localparam int CC = 2;

    logic          clk;
    logic          rst;
    logic [CC-1:0] layer_output;
    logic          start;
    logic          result_ready;
    int            result_value [CC-1:0];
    logic          result_valid;
    logic          busy;

    int checks;
    int errors;
    int last0;
    int last1;

    layer_decode #(
        .CHANNEL_COUNT (CC),
        .WINDOW_LOG2   (WL)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .layer_output (layer_output),
        .start        (start),
        .result_ready (result_ready),
        .result_value (result_value),
        .result_valid (result_valid),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int decode(input logic [NW-1:0] p);
        int ones;
        ones = $countones(p);
`ifdef LAYER_DECODE_BIPOLAR_EN
        return 2 * ones - NW;
`else
        return ones;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start edge, then NW sample edges; optional stray start at sample glitch+1.
    task automatic run_window(input logic [NW-1:0] p0, input logic [NW-1:0] p1,
                              input int glitch, input string tag);
        start = 1'b1;
        tick();
        start = 1'b0;
        check({tag, "_busy0"}, int'(busy), 1);
        for (int i = 0; i < NW; i++) begin
            layer_output = {p1[i], p0[i]};
            start = (i == glitch);
            tick();
            start = 1'b0;
            if (i == NW - 2) begin
                check({tag, "_valid_early"}, int'(result_valid), 0);
                check({tag, "_busy_late"}, int'(busy), 1);
            end
        end
        layer_output = '0;
        check({tag, "_valid"}, int'(result_valid), 1);
        check({tag, "_busy_done"}, int'(busy), 0);
        check({tag, "_ch0"}, result_value[0], decode(p0));
        check({tag, "_ch1"}, result_value[1], decode(p1));
        last0 = decode(p0);
        last1 = decode(p1);
    endtask

    initial begin
        logic [NW-1:0] r0;
        logic [NW-1:0] r1;
        checks       = 0;
        errors       = 0;
        rst          = 1'b1;
        start        = 1'b0;
        result_ready = 1'b0;
        layer_output = '0;
        repeat (3) tick();
        check("rst_valid", int'(result_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_ch0", result_value[0], 0);
        check("rst_ch1", result_value[1], 0);
        rst = 1'b0;

        // All ones / all zeros, start on first edge after reset.
        run_window(16'hFFFF, 16'h0000, -1, "ones");
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
        check("ack_valid", int'(result_valid), 0);
        check("ack_keep0", result_value[0], last0);
        check("ack_keep1", result_value[1], last1);

        // Alternating and sparse pulses, stray start mid-window.
        run_window(16'h5555, 16'h1111, 4, "alt");

        // Held result ignores start while not acknowledged.
        for (int c = 0; c < 5; c++) begin
            start = (c == 2);
            tick();
            start = 1'b0;
            check("hold_valid", int'(result_valid), 1);
            check("hold_busy", int'(busy), 0);
            check("hold_ch0", result_value[0], last0);
            check("hold_ch1", result_value[1], last1);
        end

        // Back-to-back: ready and start together in DONE.
        result_ready = 1'b1;
        run_window(16'hF00F, 16'h0FF0, -1, "b2b");
        run_window(16'h8001, 16'hFFFE, -1, "b2b2");
        result_ready = 1'b0;

        // Reset after the 7th sample discards the window.
        result_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        result_ready = 1'b0;
        layer_output = 2'b11;
        repeat (7) tick();
        rst = 1'b1;
        #1;
        check("mid_rst_valid", int'(result_valid), 0);
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_ch0", result_value[0], 0);
        check("mid_rst_ch1", result_value[1], 0);
        layer_output = '0;
        tick();
        rst = 1'b0;
        repeat (NW + 2) begin
            tick();
            check("mid_rst_no_result", int'(result_valid), 0);
        end
        run_window(16'hFFFF, 16'hAAAA, -1, "post_rst");

        // Random windows.
        for (int k = 0; k < 6; k++) begin
            result_ready = 1'b1;
            tick();
            result_ready = 1'b0;
            r0 = NW'($urandom);
            r1 = NW'($urandom);
            run_window(r0, r1, int'($urandom_range(0, 20)) - 2, "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
